// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;

    localparam logic [1:0] MDU_MUL  = 2'd0;
    localparam logic [1:0] MDU_MULU = 2'd1;
    localparam logic [1:0] MDU_DIV  = 2'd2;
    localparam logic [1:0] MDU_DIVU = 2'd3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

endpackage

// File: rtl/mdu_abs_neg.sv
// Conditional two's-complement: passes val through, or negates it when neg is set.
module mdu_abs_neg #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res_c
);

    assign res_c = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiply/divide unit for MULT, MULTU, DIV and DIVU.
// Magnitudes are processed in CALC; signs are applied on the way into hi/lo.
module muldiv_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mul_start,
    input  logic             mulu_start,
    input  logic             div_start,
    input  logic             divu_start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [1:0]       state_q, state_d;
    logic             busy_d, done_d;
    logic             start_q;
    logic             start_any_c, launch_c, last_c;
    logic [1:0]       op_sel_c;
    logic             sel_div_c, sel_signed_c;
    logic             is_div_q, neg_q_q, neg_r_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   acc_q, acc_n;
    logic [WIDTH-1:0] work_q, work_n;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH:0]   addend, sum, r_sh, diff, divisor;
    logic [WIDTH-1:0] abs_a_c, abs_b_c, fix_q_c, fix_r_c;
    logic [2*WIDTH-1:0] fix_p_c;

    assign start_any_c = mul_start | mulu_start | div_start | divu_start;
    assign launch_c    = (state_q == S_IDLE) & start_any_c & ~start_q;
    assign last_c      = (cnt_q == CNT_W'(WIDTH - 1));

    // Launch priority when several strobes rise together: div > divu > mul > mulu
    always_comb begin
        op_sel_c = MDU_MULU;
        if (div_start)       op_sel_c = MDU_DIV;
        else if (divu_start) op_sel_c = MDU_DIVU;
        else if (mul_start)  op_sel_c = MDU_MUL;
    end

    assign sel_div_c    = (op_sel_c == MDU_DIV) | (op_sel_c == MDU_DIVU);
    assign sel_signed_c = (op_sel_c == MDU_DIV) | (op_sel_c == MDU_MUL);

    mdu_abs_neg #(.W(WIDTH)) u_abs_a (.val(a), .neg(sel_signed_c & a[WIDTH-1]), .res_c(abs_a_c));
    mdu_abs_neg #(.W(WIDTH)) u_abs_b (.val(b), .neg(sel_signed_c & b[WIDTH-1]), .res_c(abs_b_c));

    // One iteration: shift-add for multiply, restoring step for divide
    always_comb begin
        acc_n   = acc_q;
        work_n  = work_q;
        divisor = {1'b0, opnd_q};
        addend  = work_q[0] ? divisor : '0;
        sum     = acc_q + addend;
        r_sh    = {acc_q[WIDTH-1:0], work_q[WIDTH-1]};
        diff    = r_sh - divisor;
        if (is_div_q) begin
            if (r_sh >= divisor) begin
                acc_n  = diff;
                work_n = {work_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_n  = r_sh;
                work_n = {work_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_n  = {1'b0, sum[WIDTH:1]};
            work_n = {sum[0], work_q[WIDTH-1:1]};
        end
    end

    // Sign fix applied to the final iteration's values as they enter hi/lo
    mdu_abs_neg #(.W(2*WIDTH)) u_fix_p (.val({acc_n[WIDTH-1:0], work_n}), .neg(neg_q_q), .res_c(fix_p_c));
    mdu_abs_neg #(.W(WIDTH))   u_fix_q (.val(work_n),             .neg(neg_q_q), .res_c(fix_q_c));
    mdu_abs_neg #(.W(WIDTH))   u_fix_r (.val(acc_n[WIDTH-1:0]),   .neg(neg_r_q), .res_c(fix_r_c));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (launch_c) begin
                    state_d = S_CALC;
                    busy_d  = 1'b1;
                end
            end
            S_CALC: begin
                if (last_c) begin
                    state_d = S_FIX;
                    done_d  = 1'b1;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Datapath, counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q  <= 1'b0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            acc_q    <= '0;
            work_q   <= '0;
            opnd_q   <= '0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            start_q <= start_any_c;
            if (launch_c) begin
                cnt_q    <= '0;
                is_div_q <= sel_div_c;
                neg_q_q  <= sel_signed_c & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r_q  <= sel_signed_c & a[WIDTH-1];
                acc_q    <= '0;
                work_q   <= sel_div_c ? abs_a_c : abs_b_c;
                opnd_q   <= sel_div_c ? abs_b_c : abs_a_c;
            end else if (state_q == S_CALC) begin
                acc_q  <= acc_n;
                work_q <= work_n;
                if (last_c) begin
                    hi <= is_div_q ? fix_r_c : fix_p_c[2*WIDTH-1:WIDTH];
                    lo <= is_div_q ? fix_q_c : fix_p_c[WIDTH-1:0];
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mul_start, mulu_start, div_start, divu_start;
    logic [31:0] a, b, hi, lo;
    logic        busy, done;

    int          n_pass = 0;
    int          n_total = 0;
    logic [63:0] last_res = '0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk(clk), .rst_n(rst_n),
        .mul_start(mul_start), .mulu_start(mulu_start),
        .div_start(div_start), .divu_start(divu_start),
        .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // 0 MULT, 1 MULTU, 2 DIV, 3 DIVU; mask bits {div, divu, mul, mulu}
    function automatic int op_of(input logic [3:0] mask);
        if (mask[3]) return 2;
        if (mask[2]) return 3;
        if (mask[1]) return 0;
        return 1;
    endfunction

    // Returns {hi, lo}
    function automatic logic [63:0] model(input int op, input logic [31:0] av, input logic [31:0] bv);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        case (op)
            0: begin q = sa * sb; p = q; return p; end
            1: begin p = {32'd0, av} * {32'd0, bv}; return p; end
            2: begin
                if (bv == 0) return {av, (av[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (bv == 0) return {av, 32'hFFFF_FFFF};
                return {av % bv, av / bv};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [3:0] mask, input logic [31:0] av,
                          input logic [31:0] bv, input int hold, input int poke_k);
        logic [63:0] exp, res_at_done;
        int busy_cnt, done_cnt, done_k, last_busy, first_busy;
        busy_cnt = 0; done_cnt = 0; done_k = -1; last_busy = -1; first_busy = -1;
        res_at_done = '0;
        exp = model(op_of(mask), av, bv);
        @(negedge clk);
        a = av;
        b = bv;
        {div_start, divu_start, mul_start, mulu_start} = mask;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k == 0) check({tag, "_hold_prev"}, {hi, lo}, last_res);
            if (busy) begin
                busy_cnt++;
                last_busy = k;
                if (first_busy < 0) first_busy = k;
            end
            if (done) begin
                done_cnt++;
                done_k = k;
                res_at_done = {hi, lo};
            end
            if (k + 1 >= hold) {div_start, divu_start, mul_start, mulu_start} = 4'b0000;
            if (k == poke_k) div_start = 1'b1;
            a = $urandom;
            b = $urandom;
        end
        check({tag, "_busy_start"}, 64'(first_busy), 64'd0);
        check({tag, "_busy_len"}, 64'(busy_cnt), 64'd33);
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        check({tag, "_done_last"}, 64'(done_k), 64'(last_busy));
        check({tag, "_res_done"}, res_at_done, exp);
        check({tag, "_res_hold"}, {hi, lo}, exp);
        last_res = exp;
    endtask

    initial begin
        logic [3:0] mask;
        int hold;
        rst_n = 1'b0;
        {div_start, divu_start, mul_start, mulu_start} = 4'b0000;
        a = '0;
        b = '0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("multu_held", 4'b0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 40, -1);
        check("multu_val", last_res, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_neg", 4'b0010, 32'hFFFF_FFFD, 32'h0000_0007, 1, -1);
        check("mult_val", last_res, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("div_neg", 4'b1000, 32'hFFFF_FFF9, 32'h0000_0002, 1, -1);
        check("div_val", last_res, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_ovf", 4'b1000, 32'h8000_0000, 32'hFFFF_FFFF, 1, -1);
        check("ovf_val", last_res, 64'h0000_0000_8000_0000);
        run_op("divu_zero", 4'b0100, 32'h0000_0007, 32'h0000_0000, 1, 5);
        check("dz_val", last_res, 64'h0000_0007_FFFF_FFFF);
        run_op("div_prio", 4'b1010, 32'd10, 32'd3, 1, -1);
        check("prio_val", last_res, 64'h0000_0001_0000_0003);

        // Reset in the middle of CALC
        @(negedge clk);
        a = 32'h1234_5678;
        b = 32'h9ABC_DEF0;
        mulu_start = 1'b1;
        @(negedge clk);
        mulu_start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_res = '0;
        run_op("post_rst", 4'b0001, 32'h0001_0000, 32'h0001_0000, 1, -1);

        for (int i = 0; i < 30; i++) begin
            mask = 4'b0001 << $urandom_range(0, 3);
            if (mask[3] || mask[2]) hold = 1;
            else hold = $urandom_range(1, 40);
            run_op($sformatf("rnd%0d", i), mask, pick(), pick(), hold, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
